control_sequencer: RTL and testbench

Multi-cycle control-step sequencer for the MiniSRC CPU. It walks each instruction through fetch steps T0–T2 and opcode-specific execute steps T3–T7. Each step drives the datapath strobes, including Gra/Grb/Grc/Rin/Rout/BAout, which feed the select-and-encode stage directly downstream. Memory steps honour a read/write acknowledge handshake.

---
 rtl/ctrl_pkg.sv | 104 ++++++++++
 rtl/ctrl_step_decode.sv | 92 +++++++++
 rtl/control_sequencer.sv | 173 +++++++++++++++++
 tb/tb_control_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the MiniSRC control sequencer.
//   state_t     - sequencer states (RST, T0..T7, STOPPED, HALTED)
//   op_class_t  - instruction classes that share a step pattern
//   OP_*        - 5-bit opcodes found in ir[31:27]
//   ALU_*       - alu_op function codes
//   strobes_t   - packed strobe bundle produced by ctrl_step_decode
// Optional feature macro used by the files importing this package: CTRL_MEM_WAIT_EN.
package ctrl_pkg;

    // T0..T7 are consecutive so the top can advance with state + 1.
    typedef enum logic [3:0] {
        ST_RST     = 4'd0,
        ST_T0      = 4'd1,
        ST_T1      = 4'd2,
        ST_T2      = 4'd3,
        ST_T3      = 4'd4,
        ST_T4      = 4'd5,
        ST_T5      = 4'd6,
        ST_T6      = 4'd7,
        ST_T7      = 4'd8,
        ST_STOPPED = 4'd9,
        ST_HALTED  = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CL_RALU, CL_IALU, CL_LD, CL_ST, CL_BR, CL_JR, CL_NOP, CL_HALT, CL_UNDEF
    } op_class_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       rin;
        logic       rout;
        logic       baout;
        logic       pcout;
        logic       pcin;
        logic       incpc;
        logic       marin;
        logic       mdrin;
        logic       mdrout;
        logic       irin;
        logic       yin;
        logic       zin;
        logic       zlowout;
        logic       cout;
        logic       conin;
        logic       read;
        logic       write;
        logic [4:0] alu_op;
        logic       run;
        logic       illegal;
    } strobes_t;

    localparam int STROBE_W = $bits(strobes_t);

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: c = CL_RALU;
            OP_ADDI, OP_ANDI, OP_ORI:      c = CL_IALU;
            OP_LD:                         c = CL_LD;
            OP_ST:                         c = CL_ST;
            OP_BR:                         c = CL_BR;
            OP_JR:                         c = CL_JR;
            OP_NOP:                        c = CL_NOP;
            OP_HALT:                       c = CL_HALT;
            default:                       c = CL_UNDEF;
        endcase
        return c;
    endfunction

    // ALU function used in T4 of the register and immediate ALU instructions.
    function automatic logic [4:0] alu_for(input logic [4:0] op);
        logic [4:0] a;
        case (op)
            OP_SUB:          a = ALU_SUB;
            OP_AND, OP_ANDI: a = ALU_AND;
            OP_OR, OP_ORI:   a = ALU_OR;
            default:         a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// ctrl_step_decode: purely combinational decode of (state, opcode, con_ff)
// into the datapath strobe bundle for the current control step.
// Ports:
//   state   in  4         current sequencer state (ctrl_pkg::state_t encoding)
//   opcode  in  5         ir[31:27]
//   con_ff  in  1         branch condition, gates the br T6 write-back
//   strobes out STROBE_W  packed ctrl_pkg::strobes_t
module ctrl_step_decode
    import ctrl_pkg::*;
(
    input  logic [3:0]          state,
    input  logic [4:0]          opcode,
    input  logic                con_ff,
    output logic [STROBE_W-1:0] strobes
);

    state_t    st;
    op_class_t cls;
    strobes_t  s;

    assign st      = state_t'(state);
    assign cls     = op_class(opcode);
    assign strobes = s;

    always_comb begin
        s = '0;
        // RST drives everything to zero; every other state defaults alu_op to ADD.
        if (st != ST_RST) s.alu_op = ALU_ADD;
        s.run = st inside {ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7};

        case (st)
            ST_T0: begin
                s.pcout = 1'b1; s.marin = 1'b1; s.incpc = 1'b1; s.zin = 1'b1;
            end
            ST_T1: begin
                s.zlowout = 1'b1; s.pcin = 1'b1; s.read = 1'b1; s.mdrin = 1'b1;
            end
            ST_T2: begin
                s.mdrout = 1'b1; s.irin = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CL_RALU, CL_IALU: begin s.grb = 1'b1; s.rout = 1'b1;  s.yin = 1'b1;   end
                    CL_LD, CL_ST:     begin s.grb = 1'b1; s.baout = 1'b1; s.yin = 1'b1;   end
                    CL_BR:            begin s.gra = 1'b1; s.rout = 1'b1;  s.conin = 1'b1; end
                    CL_JR:            begin s.gra = 1'b1; s.rout = 1'b1;  s.pcin = 1'b1;  end
                    CL_UNDEF:         s.illegal = 1'b1;
                    default:          ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_RALU: begin
                        s.grc = 1'b1; s.rout = 1'b1; s.zin = 1'b1; s.alu_op = alu_for(opcode);
                    end
                    CL_IALU: begin
                        s.cout = 1'b1; s.zin = 1'b1; s.alu_op = alu_for(opcode);
                    end
                    CL_LD, CL_ST: begin s.cout = 1'b1;  s.zin = 1'b1; end
                    CL_BR:        begin s.pcout = 1'b1; s.yin = 1'b1; end
                    default:      ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_RALU, CL_IALU: begin s.zlowout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
                    CL_LD, CL_ST:     begin s.zlowout = 1'b1; s.marin = 1'b1; end
                    CL_BR:            begin s.cout = 1'b1; s.zin = 1'b1; end
                    default:          ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CL_LD: begin s.read = 1'b1; s.mdrin = 1'b1; end
                    CL_ST: begin s.gra = 1'b1; s.rout = 1'b1; s.mdrin = 1'b1; end
                    // Branch target written back only when the condition holds.
                    CL_BR: begin s.zlowout = con_ff; s.pcin = con_ff; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CL_LD:   begin s.mdrout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
                    CL_ST:   s.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control-step sequencer for the MiniSRC CPU.
// Walks fetch steps T0-T2 and opcode-specific execute steps T3-T7; outputs are
// Moore decodes of the state register plus ir[31:27] (see ctrl_step_decode).
// Configuration macro: CTRL_MEM_WAIT_EN enables the mem_ack handshake and the
// wait counter / mem_timeout flag; without it every memory step is one cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ir[31:0]              instruction register (opcode = ir[31:27])
//   con_ff                branch condition flip-flop
//   mem_ack               memory completed the current Read/Write
//   stop                  pause request, honoured at an instruction boundary
//   Gra..BAout            register-select strobes
//   PCout..CONin          datapath strobes
//   Read, Write           memory request
//   alu_op[4:0]           ALU function for the current step
//   run                   high while executing T0..T7
//   illegal               T3 pulse for an undefined opcode
//   mem_timeout           sticky memory-wait timeout
//   state_dbg[3:0]        current state (ctrl_pkg::state_t encoding)
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ack,
    input  logic        stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        CONin,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal,
    output logic        mem_timeout,
    output logic [3:0]  state_dbg
);

    state_t                state, state_next;
    op_class_t             cls;
    logic                  mem_step, mem_done, hold, last_step;
    logic [STROBE_W-1:0]   strobe_vec;
    strobes_t              s;

    assign cls       = op_class(ir[31:27]);
    assign state_dbg = state;

    // Memory handshake: a memory step raises Read or Write and holds it, with
    // the state frozen, until a cycle in which mem_ack=1; the step ends on that
    // clock edge. mem_ack in any other step has no effect.
    assign mem_step = (state == ST_T1) ||
                      (state == ST_T6 && cls == CL_LD) ||
                      (state == ST_T7 && cls == CL_ST);
    assign hold     = mem_step && !mem_done;

    // Last execute step of each instruction class.
    assign last_step = (state == ST_T3 && cls inside {CL_JR, CL_NOP, CL_HALT, CL_UNDEF}) ||
                       (state == ST_T5 && cls inside {CL_RALU, CL_IALU}) ||
                       (state == ST_T6 && cls == CL_BR) ||
                       (state == ST_T7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RST;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST:     state_next = ST_T0;
            ST_STOPPED: if (!stop) state_next = ST_T0;
            ST_HALTED:  state_next = ST_HALTED;
            ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (hold) begin
                    state_next = state;
                end else if (last_step) begin
                    // stop is sampled only where T0 would be entered, so the
                    // current instruction always completes first.
                    if (cls == CL_HALT) state_next = ST_HALTED;
                    else if (stop)      state_next = ST_STOPPED;
                    else                state_next = ST_T0;
                end else begin
                    state_next = state_t'(state + 4'd1);
                end
            end
            default:    state_next = ST_RST;
        endcase
    end

`ifdef CTRL_MEM_WAIT_EN
    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    logic [26:0]      unused_ir;

    assign mem_done    = mem_ack;
    assign mem_timeout = timeout_q;
    assign unused_ir   = ir[26:0];

    // Counts waiting cycles of the current memory step and saturates at
    // MEM_WAIT_MAX; one more unacknowledged cycle there sets the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (mem_step && !mem_ack) begin
            if (wait_cnt == CNT_W'(MEM_WAIT_MAX)) timeout_q <= 1'b1;
            else                                  wait_cnt  <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    logic unused_ok;

    assign mem_done    = 1'b1;
    assign mem_timeout = 1'b0;
    assign unused_ok   = ^{mem_ack, ir[26:0], 32'(MEM_WAIT_MAX)};
`endif

    ctrl_step_decode u_decode (
        .state   (state),
        .opcode  (ir[31:27]),
        .con_ff  (con_ff),
        .strobes (strobe_vec)
    );

    assign s       = strobe_vec;
    assign Gra     = s.gra;
    assign Grb     = s.grb;
    assign Grc     = s.grc;
    assign Rin     = s.rin;
    assign Rout    = s.rout;
    assign BAout   = s.baout;
    assign PCout   = s.pcout;
    assign PCin    = s.pcin;
    assign IncPC   = s.incpc;
    assign MARin   = s.marin;
    assign MDRin   = s.mdrin;
    assign MDRout  = s.mdrout;
    assign IRin    = s.irin;
    assign Yin     = s.yin;
    assign Zin     = s.zin;
    assign Zlowout = s.zlowout;
    assign Cout    = s.cout;
    assign CONin   = s.conin;
    assign Read    = s.read;
    assign Write   = s.write;
    assign alu_op  = s.alu_op;
    assign run     = s.run;
    assign illegal = s.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: drives instructions cycle by cycle from a
// step-table model of the sequencer, queues the expected output word for each
// cycle, and a negedge monitor pops and compares it against the DUT outputs.
module tb_control_sequencer;

    localparam int W        = 28;
    localparam int WAIT_MAX = 15;
`ifdef CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [4:0] O_LD = 5'b00000, O_ST = 5'b00010, O_ADD = 5'b00011, O_SUB = 5'b00100;
    localparam logic [4:0] O_AND = 5'b00101, O_OR = 5'b00110, O_ADDI = 5'b01100, O_ANDI = 5'b01101;
    localparam logic [4:0] O_ORI = 5'b01110, O_BR = 5'b10010, O_JR = 5'b10100, O_NOP = 5'b11010;
    localparam logic [4:0] O_HALT = 5'b11011;
    localparam logic [4:0] A_ADD = 5'b00011, A_SUB = 5'b00100, A_AND = 5'b00101, A_OR = 5'b00110;

    // Output word layout: strobes high to low, then alu_op, run, illegal, mem_timeout.
    localparam logic [W-1:0] GRA = 28'd1 << 27, GRB = 28'd1 << 26, GRC = 28'd1 << 25;
    localparam logic [W-1:0] RIN = 28'd1 << 24, ROUT = 28'd1 << 23, BAOUT = 28'd1 << 22;
    localparam logic [W-1:0] PCOUT = 28'd1 << 21, PCIN = 28'd1 << 20, INCPC = 28'd1 << 19;
    localparam logic [W-1:0] MARIN = 28'd1 << 18, MDRIN = 28'd1 << 17, MDROUT = 28'd1 << 16;
    localparam logic [W-1:0] IRIN = 28'd1 << 15, YIN = 28'd1 << 14, ZIN = 28'd1 << 13;
    localparam logic [W-1:0] ZLOW = 28'd1 << 12, COUT = 28'd1 << 11, CONIN = 28'd1 << 10;
    localparam logic [W-1:0] READ = 28'd1 << 9, WRITE = 28'd1 << 8;
    localparam logic [W-1:0] RUN = 28'd1 << 2, ILL = 28'd1 << 1, TOUT = 28'd1;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n, con_ff, mem_ack, stop;
    logic [31:0] ir;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
    logic        IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write, run, illegal, mem_timeout;
    logic [4:0]  alu_op;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .con_ff(con_ff), .mem_ack(mem_ack), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write), .alu_op(alu_op),
        .run(run), .illegal(illegal), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    logic [W-1:0] actual;
    assign actual = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                     IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write, alu_op, run, illegal,
                     mem_timeout};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] mon_exp;
    int           mon_tag;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            n_tests++;
            if (actual !== mon_exp) begin
                n_fail++;
                $display("FAIL outputs instr=%0d step=%0d got=%h want=%h",
                         mon_tag / 16, mon_tag % 16, actual, mon_exp);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [W-1:0] steps_v[$];
    bit           steps_m[$];
    logic         timeout_model = 1'b0;
    int           instr_no = 0;

    function automatic logic [W-1:0] alu(input logic [4:0] a);
        return {20'd0, a, 3'd0};
    endfunction

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        if (op == O_SUB) return A_SUB;
        if (op == O_AND || op == O_ANDI) return A_AND;
        if (op == O_OR || op == O_ORI) return A_OR;
        return A_ADD;
    endfunction

    function automatic void add_step(input logic [W-1:0] v, input logic [4:0] a, input bit m);
        steps_v.push_back(v | alu(a));
        steps_m.push_back(m);
    endfunction

    // One entry per control step of the instruction; m marks a memory step.
    function automatic void build_steps(input logic [4:0] op, input logic con);
        steps_v.delete();
        steps_m.delete();
        add_step(PCOUT | MARIN | INCPC | ZIN, A_ADD, 0);
        add_step(ZLOW | PCIN | READ | MDRIN, A_ADD, 1);
        add_step(MDROUT | IRIN, A_ADD, 0);
        case (op)
            O_ADD, O_SUB, O_AND, O_OR: begin
                add_step(GRB | ROUT | YIN, A_ADD, 0);
                add_step(GRC | ROUT | ZIN, alu_of(op), 0);
                add_step(ZLOW | GRA | RIN, A_ADD, 0);
            end
            O_ADDI, O_ANDI, O_ORI: begin
                add_step(GRB | ROUT | YIN, A_ADD, 0);
                add_step(COUT | ZIN, alu_of(op), 0);
                add_step(ZLOW | GRA | RIN, A_ADD, 0);
            end
            O_LD, O_ST: begin
                add_step(GRB | BAOUT | YIN, A_ADD, 0);
                add_step(COUT | ZIN, A_ADD, 0);
                add_step(ZLOW | MARIN, A_ADD, 0);
                if (op == O_LD) begin
                    add_step(READ | MDRIN, A_ADD, 1);
                    add_step(MDROUT | GRA | RIN, A_ADD, 0);
                end else begin
                    add_step(GRA | ROUT | MDRIN, A_ADD, 0);
                    add_step(WRITE, A_ADD, 1);
                end
            end
            O_BR: begin
                add_step(GRA | ROUT | CONIN, A_ADD, 0);
                add_step(PCOUT | YIN, A_ADD, 0);
                add_step(COUT | ZIN, A_ADD, 0);
                add_step(con ? (ZLOW | PCIN) : '0, A_ADD, 0);
            end
            O_JR:          add_step(GRA | ROUT | PCIN, A_ADD, 0);
            O_NOP, O_HALT: add_step('0, A_ADD, 0);
            default:       add_step(ILL, A_ADD, 0);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [31:0] ir_v, input logic ack, input logic stp,
                       input logic con, input logic [W-1:0] e, input int tag);
        @(posedge clk);
        #1;
        ir      = ir_v;
        mem_ack = ack;
        stop    = stp;
        con_ff  = con;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic reset_cycles(input int n);
        for (int j = 0; j < n; j++)
            cyc($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, instr_no * 16 + 15);
        rst_n = 1'b1;
    endtask

    // w_fetch / w_exec: mem_ack-low cycles before the ack in T1 and in the
    // execute memory step. stop_end asks for a pause after the instruction,
    // lasting n_stopped+1 cycles. abort_step >= 0 asserts reset in that step.
    task automatic do_instr(input logic [4:0] op, input logic con, input int w_fetch,
                            input int w_exec, input logic stop_end, input int n_stopped,
                            input int abort_step);
        logic [31:0]  ir_v;
        logic [W-1:0] e;
        int           ncyc, w;
        logic         last, ack, stp, to_now;
        instr_no++;
        ir_v = {op, 27'($urandom)};
        build_steps(op, con);
        for (int i = 0; i < steps_v.size(); i++) begin
            w    = (i == 1) ? w_fetch : w_exec;
            ncyc = (WAIT_EN && steps_m[i]) ? w + 1 : 1;
            for (int k = 0; k < ncyc; k++) begin
                last   = (i == steps_v.size() - 1) && (k == ncyc - 1);
                ack    = (WAIT_EN && steps_m[i]) ? (k == ncyc - 1) : 1'($urandom_range(0, 1));
                stp    = last ? stop_end : 1'($urandom_range(0, 1));
                to_now = timeout_model || (WAIT_EN && steps_m[i] && k > WAIT_MAX);
                e      = steps_v[i] | RUN | (to_now ? TOUT : '0);
                // ir is don't-care during fetch, stable from T3 on.
                cyc((i < 3) ? $urandom : ir_v, ack, stp, con, e, instr_no * 16 + i);
                if (i == abort_step) begin
                    @(negedge clk);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    n_tests++;
                    if (actual !== '0) begin
                        n_fail++;
                        $display("FAIL async_reset got=%h want=%h", actual, {W{1'b0}});
                    end
                    timeout_model = 1'b0;
                    return;
                end
            end
            if (WAIT_EN && steps_m[i] && w > WAIT_MAX) timeout_model = 1'b1;
        end
        if (op != O_HALT && stop_end) begin
            for (int j = 0; j <= n_stopped; j++)
                cyc(ir_v, 1'($urandom_range(0, 1)), (j < n_stopped), con,
                    alu(A_ADD) | (timeout_model ? TOUT : '0), instr_no * 16 + 8);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [4:0] rand_ops[16] = '{O_LD, O_ST, O_ADD, O_SUB, O_AND, O_OR, O_ADDI, O_ANDI,
                                 O_ORI, O_BR, O_JR, O_NOP, 5'b11111, 5'b00001, 5'b10000,
                                 5'b01111};

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        ir      = '0;
        con_ff  = 1'b0;
        mem_ack = 1'b0;
        stop    = 1'b0;

        reset_cycles(3);

        // Directed cases.
        do_instr(O_ADD, 1'b0, 0, 0, 1'b0, 0, -1);
        do_instr(O_LD, 1'b0, 0, 2, 1'b0, 0, -1);
        do_instr(O_BR, 1'b1, 0, 0, 1'b0, 0, -1);
        do_instr(O_BR, 1'b0, 1, 0, 1'b0, 0, -1);
        do_instr(O_NOP, 1'b0, 0, 0, 1'b1, 2, -1);
        do_instr(5'b11111, 1'b0, 0, 0, 1'b0, 0, -1);
        do_instr(O_JR, 1'b1, 0, 0, 1'b0, 0, -1);
        do_instr(O_ST, 1'b0, 3, 1, 1'b1, 0, -1);
        do_instr(O_ORI, 1'b0, 0, 0, 1'b0, 0, -1);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            do_instr(rand_ops[$urandom_range(0, 15)], 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                     $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 3), -1);
        end

`ifdef CTRL_MEM_WAIT_EN
        do_instr(O_ST, 1'b0, 0, WAIT_MAX, 1'b0, 0, -1);
        do_instr(O_ST, 1'b0, 0, WAIT_MAX + 1, 1'b0, 0, -1);
        do_instr(O_ADD, 1'b0, 0, 0, 1'b0, 0, -1);
`endif

        // Reset mid-T4 of add, then restart.
        do_instr(O_ADD, 1'b0, 0, 0, 1'b0, 0, 4);
        reset_cycles(2);
        do_instr(O_SUB, 1'b0, 0, 0, 1'b0, 0, -1);

        // Halt: parked until reset regardless of stop.
        do_instr(O_HALT, 1'b0, 0, 0, 1'b0, 0, -1);
        for (int j = 0; j < 50; j++)
            cyc($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                alu(A_ADD) | (timeout_model ? TOUT : '0), instr_no * 16 + 9);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
